uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Supports configurable data width, parity mode, stop-bit count and bit period.
- Uses a valid/ready input handshake, so frames can be sent back-to-back with no idle gap.
- Sits between the network output formatter and the board TX pin, driving the serial line LSB-first.

Parameters:
CLK_PER_BIT, 4, clock cycles per serial bit (clk_frequency / baud_rate); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
data_in  input  DATA_BITS  frame payload; sampled on accept
valid  input  1  upstream has a byte to send
ready  output  1  block can accept data_in this cycle
tx  output  1  serial line; idle high
busy  output  1  a frame is in progress (START through STOP)
done  output  1  one-cycle pulse after a frame's last stop bit completes

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on posedge clk.
- Reset values: tx=1, busy=0, done=0, state=IDLE, bit counter=0, index=0. ready=0 while rst is high.
- Reset mid-frame aborts the frame; tx=1 from the cycle after rst is sampled. No done pulse is issued.
- Accept condition: valid && ready on a posedge. data_in is latched into a shift/hold register at that edge.
- ready (combinational): high in IDLE, and also in the final cycle of the final stop bit. Low otherwise.
- valid while ready=0 is ignored. data_in changes during a frame have no effect.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or -> START directly on back-to-back accept.
- IDLE: tx=1, busy=0. On accept, go to START.
- START: tx=0 for exactly CLK_PER_BIT cycles.
- DATA: tx=data[index], index 0..DATA_BITS-1 (LSB first). Each bit lasts exactly CLK_PER_BIT cycles.
- PARITY: present only if PARITY_MODE != 0; lasts CLK_PER_BIT cycles.
  - Even: parity bit = XOR-reduce(data).
  - Odd: parity bit = XNOR-reduce(data).
- STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles.
- End of STOP:
  - Accept in the final cycle: go to START next cycle; tx falls with zero idle cycles between frames.
  - No accept: go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLK_PER_BIT cycles.
- Latency: accept at edge N -> tx=0 after edge N, i.e. first start-bit cycle is N+1.
- done: registered; asserted for exactly one cycle, the cycle after the last stop-bit cycle. This holds whether the next state is IDLE or START.
- busy: high from the first START cycle through the last STOP cycle.
- Bit counter: width $clog2(CLK_PER_BIT), wraps to 0 at CLK_PER_BIT-1. Index width $clog2(DATA_BITS+1).
- Illegal or unreachable state encodings: recover to IDLE with tx=1.
- Illegal parameter values: rejected at elaboration (initial-block $error under simulation).

Decomposition:
- Shared package uart_pkg:
  - state encodings ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP;
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - The package is reused by the planned configurable RX block.
- One sub-module: uart_bit_timer.
  - Parameter CLK_PER_BIT. Inputs clk, rst, clear. Output bit_end: high in the last cycle of each bit period.
  - The FSM consumes bit_end for every state transition.

Test Plan:
- 8N1, CLK_PER_BIT=4, data_in=0xA5 accepted at cycle 0 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (cycles 1-40); done=1 at cycle 41 only; busy=1 for cycles 1-40.
- PARITY_MODE=2 (even), data 0x07 -> parity bit 1. PARITY_MODE=1 (odd), data 0x07 -> parity bit 0. Frame is 11 bits = 44 cycles.
- STOP_BITS=2, DATA_BITS=7, data 0x41 -> stop high for 8 cycles; total frame 40 cycles; ready rises only in the last stop cycle.
- Back-to-back: valid held high with 0x55 then 0xAA -> second start bit begins the cycle after the first frame's last stop cycle; no idle gap; done pulse coincides with the second frame's first start-bit cycle.
- rst asserted in DATA at bit 3 -> tx=1, busy=0, ready=0 during reset, no done pulse. A new frame 0x3C after release transmits correctly.
- valid pulsed with 0xFF while busy -> ignored; frame in progress unchanged; no extra frame sent afterward.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : State encodings, parity modes and the parity helper shared by
//               the configurable UART TX and RX blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Unused upper bits must be zero; they do not disturb the reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Free-running bit-period counter; bit_end marks the last cycle
//               of each CLK_PER_BIT-cycle serial bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int                 c_CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bit_end = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised LSB-first UART transmitter with valid/ready input
//               and gapless back-to-back framing.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 4,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int               c_IDX_W      = $clog2(DATA_BITS + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
    localparam bit               c_HAS_PARITY = (PARITY_MODE != PAR_NONE);
    localparam logic             c_LAST_STOP  = 1'(STOP_BITS - 1);

    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535) begin : g_bad_clk_per_bit
        $error("uart_tx_cfg: CLK_PER_BIT out of range 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS out of range 5..9");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_ODD && PARITY_MODE != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_par;
    logic                 r_stop_idx;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    logic w_bit_end;
    logic w_last_stop;
    logic w_ready;
    logic w_accept;

    uart_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == ST_IDLE),
        .bit_end(w_bit_end)
    );

    assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_stop_idx == c_LAST_STOP);
    assign w_ready     = !rst && ((r_state == ST_IDLE) || w_last_stop);
    assign w_accept    = valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_par      <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_stop;
            // Accept can only occur in IDLE or the final stop cycle, so it takes priority.
            if (w_accept) begin
                r_state <= ST_START;
                r_shift <= data_in;
                r_par   <= calc_parity(MAX_DATA_BITS'(data_in), PARITY_MODE);
                r_idx   <= '0;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            r_state <= ST_DATA;
                            r_tx    <= r_shift[0];
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            if (r_idx == c_LAST_IDX) begin
                                r_stop_idx <= 1'b0;
                                if (c_HAS_PARITY) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state <= ST_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_idx   <= r_idx + c_IDX_W'(1);
                                r_shift <= r_shift >> 1;
                                r_tx    <= r_shift[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= ST_STOP;
                            r_stop_idx <= 1'b0;
                            r_tx       <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_last_stop) begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_bit_end) begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready = w_ready;
    assign tx    = r_tx;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench driving five uart_tx_cfg configurations
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int N = 5;
    localparam int DB [N] = '{8, 8, 8, 7, 9};
    localparam int PM [N] = '{0, 2, 1, 0, 2};
    localparam int SB [N] = '{1, 1, 1, 2, 2};
    localparam int CPB[N] = '{4, 4, 4, 4, 5};

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] din[N];
    logic       vld[N];
    logic       rdy[N];
    logic       txl[N];
    logic       bsy[N];
    logic       dn [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(din[0][7:0]), .valid(vld[0]),
        .ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .done(dn[0]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din[1][7:0]), .valid(vld[1]),
        .ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .done(dn[1]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(din[2][7:0]), .valid(vld[2]),
        .ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .done(dn[2]));
    uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(din[3][6:0]), .valid(vld[3]),
        .ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]), .done(dn[3]));
    uart_tx_cfg #(.CLK_PER_BIT(5), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(din[4][8:0]), .valid(vld[4]),
        .ready(rdy[4]), .tx(txl[4]), .busy(bsy[4]), .done(dn[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial levels of one frame, one entry per bit period.
    function automatic bitq_t frame_bits(input int k, input logic [8:0] d_raw);
        bitq_t      q;
        logic [8:0] d;
        int         ones;
        d = d_raw & 9'((1 << DB[k]) - 1);
        q.push_back(1'b0);
        for (int i = 0; i < DB[k]; i++) q.push_back(d[i]);
        if (PM[k] != 0) begin
            ones = $countones(d);
            q.push_back((PM[k] == 2) ? bit'(ones % 2) : bit'(1 - ones % 2));
        end
        for (int i = 0; i < SB[k]; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic idle_check(input int k, input string tag);
        @(posedge clk); #1;
        chk($sformatf("%s k%0d tx", tag, k), txl[k], 1);
        chk($sformatf("%s k%0d busy", tag, k), bsy[k], 0);
        chk($sformatf("%s k%0d ready", tag, k), rdy[k], 1);
        chk($sformatf("%s k%0d done", tag, k), dn[k], 0);
    endtask

    // Caller has driven valid/data for the accept edge (or chained it from the previous frame).
    task automatic frame(input int k, input logic [8:0] d, input bit done0, input bit chain,
                         input logic [8:0] nd, input bit rand_inject, input int pulse_j);
        bitq_t b;
        int    len;
        b   = frame_bits(k, d);
        len = b.size() * CPB[k];
        for (int j = 0; j < len; j++) begin
            @(posedge clk); #1;
            vld[k] = 1'b0;
            chk($sformatf("k%0d d%0h tx j%0d", k, d, j), txl[k], b[j / CPB[k]]);
            chk($sformatf("k%0d d%0h busy j%0d", k, d, j), bsy[k], 1);
            chk($sformatf("k%0d d%0h ready j%0d", k, d, j), rdy[k], (j == len - 1) ? 1 : 0);
            chk($sformatf("k%0d d%0h done j%0d", k, d, j), dn[k], (j == 0 && done0) ? 1 : 0);
            if (j == len - 1 && chain) begin
                vld[k] = 1'b1;
                din[k] = nd;
            end else if (j < len - 1 && (j == pulse_j || (rand_inject && $urandom_range(0, 5) == 0))) begin
                vld[k] = 1'b1;
                din[k] = (j == pulse_j) ? 9'h1FF : 9'($urandom);
            end
        end
        if (!chain) begin
            @(posedge clk); #1;
            chk($sformatf("k%0d end done", k), dn[k], 1);
            chk($sformatf("k%0d end tx", k), txl[k], 1);
            chk($sformatf("k%0d end busy", k), bsy[k], 0);
            chk($sformatf("k%0d end ready", k), rdy[k], 1);
            idle_check(k, "post");
        end
    endtask

    task automatic send(input int k, input logic [8:0] d);
        chk($sformatf("k%0d ready before accept", k), rdy[k], 1);
        vld[k] = 1'b1;
        din[k] = d;
        frame(k, d, 1'b0, 1'b0, 9'h0, 1'b0, -1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        logic [8:0] nd;
        int         k;
        int         nfr;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            din[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset k%0d tx", i), txl[i], 1);
            chk($sformatf("reset k%0d busy", i), bsy[i], 0);
            chk($sformatf("reset k%0d done", i), dn[i], 0);
            chk($sformatf("reset k%0d ready", i), rdy[i], 0);
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) idle_check(i, "after_reset");

        send(0, 9'h0A5);
        send(1, 9'h007);
        send(2, 9'h007);
        send(3, 9'h041);
        send(4, 9'h1A3);

        // Back-to-back with valid held across the frame boundary.
        vld[0] = 1'b1;
        din[0] = 9'h055;
        frame(0, 9'h055, 1'b0, 1'b1, 9'h0AA, 1'b0, -1);
        frame(0, 9'h0AA, 1'b1, 1'b0, 9'h000, 1'b0, -1);

        // Reset while DATA bit 3 is on the line.
        vld[0] = 1'b1;
        din[0] = 9'h096;
        repeat ((1 + 3) * CPB[0] + 2) begin
            @(posedge clk); #1;
            vld[0] = 1'b0;
        end
        chk("midrst busy before", bsy[0], 1);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("midrst tx", txl[0], 1);
            chk("midrst busy", bsy[0], 0);
            chk("midrst ready", rdy[0], 0);
            chk("midrst done", dn[0], 0);
        end
        rst = 1'b0;
        repeat (3) idle_check(0, "midrst_release");
        send(0, 9'h03C);

        // Valid pulse with 0xFF while busy must be ignored.
        vld[0] = 1'b1;
        din[0] = 9'h012;
        frame(0, 9'h012, 1'b0, 1'b0, 9'h000, 1'b0, 13);
        repeat (CPB[0] * 2) idle_check(0, "no_extra");

        repeat (40) begin
            k   = $urandom_range(0, N - 1);
            nfr = $urandom_range(1, 3);
            d   = 9'($urandom);
            vld[k] = 1'b1;
            din[k] = d;
            for (int f = 0; f < nfr; f++) begin
                nd = 9'($urandom);
                frame(k, d, f > 0, f < nfr - 1, nd, 1'b1, -1);
                d = nd;
            end
            repeat ($urandom_range(0, 3)) idle_check(k, "gap");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
